// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control-bundle types and halt FSM states for the
// RV32I main-control decode stage.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_HALT   = 7'b1111111;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_ITYPE  = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        RW_ALU_MEM = 2'b00,
        RW_PC4     = 2'b01,
        RW_IMM     = 2'b10,
        RW_PC_IMM  = 2'b11
    } rwsel_e;

    typedef struct packed {
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        aluop_e alu_op;
        logic   branch;
        logic   jump;
        logic   jalr_sel;
        rwsel_e rw_sel;
        logic   illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '{
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        alu_op:     ALU_ADD,
        branch:     1'b0,
        jump:       1'b0,
        jalr_sel:   1'b0,
        rw_sel:     RW_ALU_MEM,
        illegal:    1'b0
    };

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DRAIN   = 2'b01,
        HALTED  = 2'b10
    } halt_state_e;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode -> control-bundle decoder. HALT decodes to an
// all-zero bundle; anything unrecognised sets only the illegal flag.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output ctrl_bundle_t        o_ctrl
);

    always_comb begin
        // NOTE: default the whole bundle first so no path through the case leaves a field unassigned (no latch).
        o_ctrl = CTRL_BUBBLE;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_RTYPE;
            end
            OP_ITYPE: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALU_ITYPE;
            end
            OP_LOAD: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_read   = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_BRANCH;
            end
            OP_JAL: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.rw_sel    = RW_PC4;
            end
            OP_JALR: begin
                o_ctrl.jump      = 1'b1;
                o_ctrl.jalr_sel  = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.rw_sel    = RW_PC4;
            end
            OP_LUI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.rw_sel    = RW_IMM;
            end
            OP_AUIPC: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.rw_sel    = RW_PC_IMM;
            end
            OP_HALT: begin
                o_ctrl = CTRL_BUBBLE;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// ID/EX control register with stall/flush handling plus the halt FSM that
// stops fetch, drains for DRAIN_CYCLES and then reports halted.
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 7,
    parameter int ALUOP_W      = 2,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = $clog2(DRAIN_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic                ALUSrc,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                Branch,
    output logic                Jump,
    output logic                JalrSel,
    output logic [1:0]          RWSel,
    output logic                valid_o,
    output logic                illegal_o,
    output logic                fetch_en_o,
    output logic                halted_o
);

    ctrl_bundle_t w_dec;
    logic         w_halt_accept;

    ctrl_bundle_t r_ctrl;
    logic         r_valid;
    halt_state_e  r_state;
    logic [CNT_W-1:0] r_count;
    logic         r_halted;

    ctrl_decode_comb #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .i_opcode (opcode_i),
        .o_ctrl   (w_dec)
    );

    assign w_halt_accept = (r_state == RUN) && valid_i && (opcode_i == OP_HALT)
                           && !stall_i && !flush_i;

    // ID/EX boundary register. HALTED ignores flush/stall and only ever loads bubbles.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else if (r_state == HALTED || flush_i) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else if (stall_i) begin
            r_ctrl  <= r_ctrl;
            r_valid <= r_valid;
        end else if (r_state != RUN || !valid_i) begin
            r_ctrl  <= CTRL_BUBBLE;
            r_valid <= 1'b0;
        end else begin
            r_ctrl  <= w_dec;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= RUN;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_accept) begin
                        r_state <= DRAIN;
                        r_count <= CNT_W'(DRAIN_CYCLES);
                    end
                end
                DRAIN: begin
                    // A flush means the HALT was on a squashed path: resume.
                    if (flush_i) begin
                        r_state <= RUN;
                        r_count <= '0;
                    end else if (!stall_i) begin
                        if (r_count == CNT_W'(1)) begin
                            r_state  <= HALTED;
                            r_count  <= '0;
                            r_halted <= 1'b1;
                        end else begin
                            r_count <= r_count - CNT_W'(1);
                        end
                    end
                end
                HALTED: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= RUN;
                    r_count  <= '0;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_en_o = (r_state == RUN) && !stall_i;

    assign ALUSrc    = r_ctrl.alu_src;
    assign MemtoReg  = r_ctrl.mem_to_reg;
    assign RegWrite  = r_ctrl.reg_write;
    assign MemRead   = r_ctrl.mem_read;
    assign MemWrite  = r_ctrl.mem_write;
    assign ALUOp     = ALUOP_W'(r_ctrl.alu_op);
    assign Branch    = r_ctrl.branch;
    assign Jump      = r_ctrl.jump;
    assign JalrSel   = r_ctrl.jalr_sel;
    assign RWSel     = r_ctrl.rw_sel;
    assign valid_o   = r_valid;
    assign illegal_o = r_ctrl.illegal;
    assign halted_o  = r_halted;

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Directed scoreboard bench for ctrl_decode_pipe: expected ID/EX bundles are
// queued when stimulus is driven and compared one edge later.
module tb_ctrl_decode_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i;
    logic [6:0] opcode_i;
    logic       stall_i;
    logic       flush_i;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
    logic [1:0] ALUOp;
    logic       Branch, Jump, JalrSel;
    logic [1:0] RWSel;
    logic       valid_o, illegal_o, fetch_en_o, halted_o;

    ctrl_decode_pipe dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .opcode_i   (opcode_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .Branch     (Branch),
        .Jump       (Jump),
        .JalrSel    (JalrSel),
        .RWSel      (RWSel),
        .valid_o    (valid_o),
        .illegal_o  (illegal_o),
        .fetch_en_o (fetch_en_o),
        .halted_o   (halted_o)
    );

    always #5 clk = ~clk;

    // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,ALUOp[1:0],Branch,Jump,JalrSel,RWSel[1:0],valid,illegal}
    typedef logic [13:0] vec_t;

    localparam vec_t BUBBLE = 14'd0;

    vec_t  sb_q[$];
    string tag_q[$];
    vec_t  cur;
    int    total = 0;
    int    bad   = 0;

    function automatic vec_t ctl(input logic src, input logic m2r, input logic rw,
                                 input logic mr, input logic mw, input logic [1:0] aop,
                                 input logic br, input logic jp, input logic jr,
                                 input logic [1:0] rws);
        return {src, m2r, rw, mr, mw, aop, br, jp, jr, rws, 1'b1, 1'b0};
    endfunction

    function automatic vec_t exp_dec(input logic [6:0] op);
        case (op)
            7'b0110011: return ctl(0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 2'b00);
            7'b0010011: return ctl(1, 0, 1, 0, 0, 2'b11, 0, 0, 0, 2'b00);
            7'b0000011: return ctl(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 2'b00);
            7'b0100011: return ctl(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 2'b00);
            7'b1100011: return ctl(0, 0, 0, 0, 0, 2'b01, 1, 0, 0, 2'b00);
            7'b1101111: return ctl(0, 0, 1, 0, 0, 2'b00, 0, 1, 0, 2'b01);
            7'b1100111: return ctl(1, 0, 1, 0, 0, 2'b00, 0, 1, 1, 2'b01);
            7'b0110111: return ctl(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b10);
            7'b0010111: return ctl(1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 2'b11);
            7'b1111111: return 14'b00000000000010;
            default:    return 14'b00000000000011;
        endcase
    endfunction

    function automatic vec_t observed();
        return {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp,
                Branch, Jump, JalrSel, RWSel, valid_o, illegal_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of ID inputs, check combinational fetch_en before the
    // edge, then pop the queued bundle and check halted after the edge.
    task automatic step(input string tag, input logic v, input logic [6:0] op,
                        input logic st, input logic fl, input vec_t exp,
                        input logic exp_fetch, input logic exp_halted);
        vec_t  e;
        string t;
        @(negedge clk);
        valid_i  = v;
        opcode_i = op;
        stall_i  = st;
        flush_i  = fl;
        #1;
        check({tag, ".fetch_en"}, 32'(fetch_en_o), 32'(exp_fetch));
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        cur = exp;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".bundle"}, 32'(observed()), 32'(e));
        check({t, ".halted"}, 32'(halted_o), 32'(exp_halted));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b1;
        valid_i  = 1'b0;
        opcode_i = 7'd0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        @(posedge clk);
        #1;
        check({tag, ".bundle"}, 32'(observed()), 32'(BUBBLE));
        check({tag, ".halted"}, 32'(halted_o), 32'd0);
        check({tag, ".fetch_en"}, 32'(fetch_en_o), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        cur   = BUBBLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [5];
        reset    = 1'b1;
        valid_i  = 1'b0;
        opcode_i = 7'd0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        cur      = BUBBLE;
        repeat (2) @(posedge clk);
        do_reset("reset0");

        step("rtype", 1, 7'b0110011, 0, 0, exp_dec(7'b0110011), 1, 0);

        // LW then S held in ID under a two-cycle stall.
        step("lw",        1, 7'b0000011, 0, 0, exp_dec(7'b0000011), 1, 0);
        step("lw_hold1",  1, 7'b0100011, 1, 0, cur,                 0, 0);
        step("lw_hold2",  1, 7'b0100011, 1, 0, cur,                 0, 0);
        step("store",     1, 7'b0100011, 0, 0, exp_dec(7'b0100011), 1, 0);

        step("jalr_flush", 1, 7'b1100111, 0, 1, BUBBLE,              1, 0);
        step("jalr",       1, 7'b1100111, 0, 0, exp_dec(7'b1100111), 1, 0);
        step("illegal0",   1, 7'b0000000, 0, 0, exp_dec(7'b0000000), 1, 0);
        step("invalid_r",  0, 7'b0110011, 0, 0, BUBBLE,              1, 0);

        ops[0] = 7'b0010011;
        ops[1] = 7'b1100011;
        ops[2] = 7'b1101111;
        ops[3] = 7'b0110111;
        ops[4] = 7'b0010111;
        for (int i = 0; i < 5; i++)
            step($sformatf("op%0d", i), 1, ops[i], 0, 0, exp_dec(ops[i]), 1, 0);

        // HALT accepted; a second HALT during drain must not load.
        step("halt_acc", 1, 7'b1111111, 0, 0, exp_dec(7'b1111111), 1, 0);
        step("drain1",   1, 7'b1111111, 0, 0, BUBBLE, 0, 0);
        step("drain2",   1, 7'b0110011, 0, 0, BUBBLE, 0, 0);
        step("drain3",   1, 7'b0110011, 0, 0, BUBBLE, 0, 0);
        step("drain4",   1, 7'b0110011, 0, 0, BUBBLE, 0, 1);
        for (int i = 0; i < 10; i++)
            step($sformatf("halted%0d", i), 1, 7'b0110011, i[0], i[1], BUBBLE, 0, 1);

        do_reset("reset1");
        step("post_reset", 1, 7'b0110011, 0, 0, exp_dec(7'b0110011), 1, 0);

        // HALT stalled in ID is not accepted; flush in the second drain cycle cancels.
        step("halt_stall", 1, 7'b1111111, 1, 0, cur,                 0, 0);
        step("halt_acc2",  1, 7'b1111111, 0, 0, exp_dec(7'b1111111), 1, 0);
        step("drain_a",    1, 7'b0110011, 0, 0, BUBBLE,              0, 0);
        step("drain_flush",1, 7'b0110011, 0, 1, BUBBLE,              0, 0);
        step("resume",     1, 7'b0000011, 0, 0, exp_dec(7'b0000011), 1, 0);
        for (int i = 0; i < 6; i++)
            step($sformatf("run%0d", i), 1, 7'b0110011, 0, 0, exp_dec(7'b0110011), 1, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
